// File: rtl/transpose_block_sequencer_if.sv
// Handshake and status bundle between transpose_block_sequencer, its upstream column source,
// the transpose buffer and the downstream row sink.
interface transpose_block_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 col_valid_in;
    logic                 col_ready_out;
    logic                 buf_rst_out;
    logic                 buf_valid_out;
    logic                 buf_row_valid_in;
    logic                 buf_final_row_in;
    logic                 row_valid_out;
    logic                 row_last_out;
    logic                 credit_return_in;
    logic [7:0]           credit_count_out;
    logic [CNT_WIDTH-1:0] block_count_out;
    logic                 busy_out;
    logic                 error_out;

    // Sequencer side
    modport master (
        input  col_valid_in, buf_row_valid_in, buf_final_row_in, credit_return_in,
        output col_ready_out, buf_rst_out, buf_valid_out, row_valid_out, row_last_out,
               credit_count_out, block_count_out, busy_out, error_out
    );

    // Environment side
    modport slave (
        output col_valid_in, buf_row_valid_in, buf_final_row_in, credit_return_in,
        input  col_ready_out, buf_rst_out, buf_valid_out, row_valid_out, row_last_out,
               credit_count_out, block_count_out, busy_out, error_out
    );
endinterface

// File: rtl/transpose_block_sequencer.sv
// Control sequencer for an 8x8 transpose buffer: admits one block of 8 column beats only when
// 8 downstream row credits are reserved, then forwards the 8-row drain to the sink.
module transpose_block_sequencer #(
    parameter int unsigned CREDITS       = 16,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 12
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    transpose_block_sequencer_if.master bus
);

    localparam int unsigned DrainW      = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [7:0]  CreditsInit = 8'(CREDITS);

    typedef enum logic [1:0] {StRst, StIdle, StLoad, StDrain} state_e;

    state_e               state_q, state_d;
    logic                 hold_cnt_q, hold_cnt_d;
    logic [2:0]           col_cnt_q, col_cnt_d;
    logic [2:0]           row_cnt_q, row_cnt_d;
    logic [DrainW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [7:0]           credits_q, credits_d;
    logic [CNT_WIDTH-1:0] blocks_q, blocks_d;
    logic                 error_q, error_d;

    logic       col_ready;
    logic       col_hs;
    logic       row_beat;
    logic       final_beat;
    logic       reserve;
    logic       timeout;
    logic [8:0] credit_sum;

    assign col_ready  = (state_q == StLoad);
    assign col_hs     = bus.col_valid_in && col_ready;
    assign row_beat   = bus.buf_row_valid_in && (state_q == StDrain);
    assign final_beat = row_beat && bus.buf_final_row_in;

    assign bus.col_ready_out    = col_ready;
    assign bus.buf_valid_out    = col_hs;
    assign bus.buf_rst_out      = (state_q == StRst);
    assign bus.row_valid_out    = row_beat;
    assign bus.row_last_out     = final_beat;
    assign bus.credit_count_out = credits_q;
    assign bus.block_count_out  = blocks_q;
    assign bus.busy_out         = (state_q == StLoad) || (state_q == StDrain);
    assign bus.error_out        = error_q;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        blocks_d    = blocks_q;
        error_d     = error_q;
        reserve     = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            StRst: begin
                // Hold the buffer in reset for two cycles after entry
                if (hold_cnt_q) begin
                    hold_cnt_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    hold_cnt_d = 1'b1;
                end
            end
            StIdle: begin
                if ((credits_q >= 8'd8) && !error_q) begin
                    reserve   = 1'b1;
                    col_cnt_d = 3'd0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (col_hs) begin
                    if (col_cnt_q == 3'd7) begin
                        col_cnt_d   = 3'd0;
                        row_cnt_d   = 3'd0;
                        drain_cnt_d = '0;
                        state_d     = StDrain;
                    end else begin
                        col_cnt_d = col_cnt_q + 3'd1;
                    end
                end
            end
            StDrain: begin
                if (row_beat && (row_cnt_q != 3'd7)) begin
                    row_cnt_d = row_cnt_q + 3'd1;
                end
                if (final_beat) begin
                    blocks_d  = blocks_q + CNT_WIDTH'(1);
                    row_cnt_d = 3'd0;
                    state_d   = StIdle;
                end else if (drain_cnt_q == DrainW'(DRAIN_TIMEOUT - 1)) begin
                    // Buffer never signalled its final row: abandon and re-reset it
                    timeout    = 1'b1;
                    error_d    = 1'b1;
                    hold_cnt_d = 1'b0;
                    row_cnt_d  = 3'd0;
                    state_d    = StRst;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            default: state_d = StRst;
        endcase

        if (bus.buf_row_valid_in && (state_q != StDrain)) begin
            error_d = 1'b1;
        end
        if (bus.buf_final_row_in && (row_cnt_q != 3'd7)) begin
            error_d = 1'b1;
        end

        credit_sum = {1'b0, credits_q} + {8'd0, bus.credit_return_in}
                   - (reserve ? 9'd8 : 9'd0);
        credits_d  = credit_sum[7:0];
        if (timeout) begin
            credits_d = CreditsInit;
        end else if (credit_sum > 9'(CREDITS)) begin
            error_d   = 1'b1;
            credits_d = CreditsInit;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StRst;
            hold_cnt_q  <= 1'b0;
            col_cnt_q   <= 3'd0;
            row_cnt_q   <= 3'd0;
            drain_cnt_q <= '0;
            credits_q   <= CreditsInit;
            blocks_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            credits_q   <= credits_d;
            blocks_q    <= blocks_d;
            error_q     <= error_d;
        end
    end

endmodule
